controlador_cafe: RTL and testbench

CONTROLADOR_CAFE -- requirements
Module: controlador_cafe

---
 rtl/controlador_cafe.sv | 235 +++++++++++++++++++++++
 tb/tb_controlador_cafe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_cafe.sv
// Coffee vending controller: accumulates coins, checks price, runs the timed
// valve sequence of the selected drink and returns change or refunds.
module controlador_cafe #(
    parameter int unsigned TIEMPO_PASO = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       moneda_valida,
    input  logic [3:0] moneda_valor,
    input  logic [3:0] cafe,
    input  logic       confirmar,
    input  logic       cancelar,
    output logic [3:0] credito,
    output logic [1:0] tipoCafe,
    output logic [3:0] valvulas,
    output logic       ocupado,
    output logic [3:0] vuelto,
    output logic       vuelto_valido,
    output logic       moneda_rechazo,
    output logic       saldo_insuf,
    output logic       listo
);

    localparam int unsigned W_CRED = 4;
    localparam int unsigned W_CNT  = 8;
    localparam int unsigned W_PASO = 2;

    localparam logic [W_CNT-1:0]  CNT_FIN   = W_CNT'(TIEMPO_PASO - 1);
    localparam logic [W_CRED:0]   CRED_MAX  = (W_CRED+1)'(15);

    localparam logic [3:0] V_NADA  = 4'b0000;
    localparam logic [3:0] V_AGUA  = 4'b0001;
    localparam logic [3:0] V_CAFE  = 4'b0010;
    localparam logic [3:0] V_LECHE = 4'b0100;
    localparam logic [3:0] V_CHOC  = 4'b1000;

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        ACUMULA = 2'd1,
        PREPARA = 2'd2,
        ENTREGA = 2'd3
    } estado_t;

    // Non-one-hot selections fall back to mocaccino.
    function automatic logic [1:0] decodifica(input logic [3:0] sel);
        case (sel)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [W_CRED-1:0] precio_de(input logic [1:0] t);
        case (t)
            2'd0:    return W_CRED'(3);
            2'd1:    return W_CRED'(4);
            2'd2:    return W_CRED'(5);
            default: return W_CRED'(7);
        endcase
    endfunction

    function automatic logic [W_PASO-1:0] ultimo_paso(input logic [1:0] t);
        case (t)
            2'd0:    return W_PASO'(1);
            2'd1:    return W_PASO'(2);
            default: return W_PASO'(3);
        endcase
    endfunction

    function automatic logic [3:0] valvula_de(input logic [1:0] t, input logic [W_PASO-1:0] p);
        case (p)
            2'd0:    return V_AGUA;
            2'd1:    return V_CAFE;
            2'd2:    return (t == 2'd0) ? V_NADA : V_LECHE;
            default: begin
                case (t)
                    2'd2:    return V_LECHE;
                    2'd3:    return V_CHOC;
                    default: return V_NADA;
                endcase
            end
        endcase
    endfunction

    estado_t             state_q, state_d;
    logic [W_CRED-1:0]   credito_q, credito_d;
    logic [1:0]          tipo_q, tipo_d;
    logic [W_CRED-1:0]   precio_q, precio_d;
    logic [W_PASO-1:0]   paso_q, paso_d;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [3:0]          valv_q, valv_d;
    logic [W_CRED-1:0]   vuelto_q, vuelto_d;
    logic                vv_q, vv_d;
    logic                rech_q, rech_d;
    logic                insuf_q, insuf_d;
    logic                listo_q, listo_d;

    logic [W_CRED:0]     suma;
    logic                acepta;
    logic [1:0]          tipo_sel;
    logic [W_CRED-1:0]   precio_sel;

    // Coin acceptance uses a carry bit so overflow above 15 is refused, not wrapped.
    always_comb begin
        suma       = {1'b0, credito_q} + {1'b0, moneda_valor};
        acepta     = moneda_valida && (moneda_valor != 4'd0) && (suma <= CRED_MAX)
                     && ((state_q == ESPERA) || (state_q == ACUMULA));
        tipo_sel   = decodifica(cafe);
        precio_sel = precio_de(tipo_sel);
    end

    always_comb begin
        state_d   = state_q;
        credito_d = credito_q;
        tipo_d    = tipo_q;
        precio_d  = precio_q;
        paso_d    = paso_q;
        cnt_d     = cnt_q;
        valv_d    = V_NADA;
        vuelto_d  = '0;
        vv_d      = 1'b0;
        rech_d    = moneda_valida && !acepta;
        insuf_d   = 1'b0;
        listo_d   = 1'b0;

        case (state_q)
            ESPERA: begin
                if (acepta) begin
                    credito_d = suma[W_CRED-1:0];
                    state_d   = ACUMULA;
                end
                if (confirmar) begin
                    insuf_d = 1'b1;
                end
            end

            ACUMULA: begin
                if (cancelar) begin
                    // A coin arriving with cancel is refunded along with the credit.
                    vuelto_d  = acepta ? suma[W_CRED-1:0] : credito_q;
                    vv_d      = 1'b1;
                    credito_d = '0;
                    state_d   = ESPERA;
                end else begin
                    if (acepta) begin
                        credito_d = suma[W_CRED-1:0];
                    end
                    if (confirmar) begin
                        if (credito_q >= precio_sel) begin
                            tipo_d   = tipo_sel;
                            precio_d = precio_sel;
                            paso_d   = '0;
                            cnt_d    = '0;
                            valv_d   = V_AGUA;
                            state_d  = PREPARA;
                        end else begin
                            insuf_d = 1'b1;
                        end
                    end
                end
            end

            PREPARA: begin
                if (cnt_q == CNT_FIN) begin
                    cnt_d = '0;
                    if (paso_q == ultimo_paso(tipo_q)) begin
                        vuelto_d = credito_q - precio_q;
                        vv_d     = 1'b1;
                        listo_d  = 1'b1;
                        state_d  = ENTREGA;
                    end else begin
                        paso_d = W_PASO'(paso_q + W_PASO'(1));
                        valv_d = valvula_de(tipo_q, W_PASO'(paso_q + W_PASO'(1)));
                    end
                end else begin
                    cnt_d  = W_CNT'(cnt_q + W_CNT'(1));
                    valv_d = valvula_de(tipo_q, paso_q);
                end
            end

            ENTREGA: begin
                credito_d = '0;
                paso_d    = '0;
                state_d   = ESPERA;
            end

            default: begin
                state_d = ESPERA;
            end
        endcase
    end

    // Asynchronous reset also drops the valve drive without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ESPERA;
            credito_q <= '0;
            tipo_q    <= '0;
            precio_q  <= '0;
            paso_q    <= '0;
            cnt_q     <= '0;
            valv_q    <= V_NADA;
            vuelto_q  <= '0;
            vv_q      <= 1'b0;
            rech_q    <= 1'b0;
            insuf_q   <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            credito_q <= credito_d;
            tipo_q    <= tipo_d;
            precio_q  <= precio_d;
            paso_q    <= paso_d;
            cnt_q     <= cnt_d;
            valv_q    <= valv_d;
            vuelto_q  <= vuelto_d;
            vv_q      <= vv_d;
            rech_q    <= rech_d;
            insuf_q   <= insuf_d;
            listo_q   <= listo_d;
        end
    end

    assign credito        = credito_q;
    assign tipoCafe       = tipo_q;
    assign valvulas       = valv_q;
    assign ocupado        = (state_q == PREPARA) || (state_q == ENTREGA);
    assign vuelto         = vuelto_q;
    assign vuelto_valido  = vv_q;
    assign moneda_rechazo = rech_q;
    assign saldo_insuf    = insuf_q;
    assign listo          = listo_q;

endmodule

// File: tb/tb_controlador_cafe.sv
// Scoreboard bench for controlador_cafe: stimulus queues expected events,
// a negedge monitor pops and compares pulses and valve-run lengths.
module tb_controlador_cafe;

    localparam int K_VALV  = 1;
    localparam int K_RECH  = 2;
    localparam int K_INSUF = 3;
    localparam int K_VUEL  = 4;
    localparam int K_LISTO = 5;

    typedef struct {
        int kind;
        int data;
        int len;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       moneda_valida = 1'b0;
    logic [3:0] moneda_valor = 4'd0;
    logic [3:0] cafe = 4'b0001;
    logic       confirmar = 1'b0;
    logic       cancelar = 1'b0;
    logic [3:0] credito;
    logic [1:0] tipoCafe;
    logic [3:0] valvulas;
    logic       ocupado;
    logic [3:0] vuelto;
    logic       vuelto_valido;
    logic       moneda_rechazo;
    logic       saldo_insuf;
    logic       listo;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;

    controlador_cafe #(.TIEMPO_PASO(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .moneda_valida(moneda_valida), .moneda_valor(moneda_valor),
        .cafe(cafe), .confirmar(confirmar), .cancelar(cancelar),
        .credito(credito), .tipoCafe(tipoCafe), .valvulas(valvulas),
        .ocupado(ocupado), .vuelto(vuelto), .vuelto_valido(vuelto_valido),
        .moneda_rechazo(moneda_rechazo), .saldo_insuf(saldo_insuf), .listo(listo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic esperar(input int kind, input int data, input int len);
        ev_t e;
        e.kind = kind; e.data = data; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic emitir(input int kind, input int data, input int len);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind=%0d data=%0d len=%0d expected none at %0t",
                     kind, data, len, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data || e.len != len) begin
                failures++;
                $display("FAIL event: got kind=%0d data=%0d len=%0d expected kind=%0d data=%0d len=%0d at %0t",
                         kind, data, len, e.kind, e.data, e.len, $time);
            end
        end
    endtask

    // Monitor: valve runs are reported when they end; pulses are reported as seen.
    initial begin
        logic [3:0] prev;
        int         run;
        prev = 4'd0;
        run  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 4'd0;
                run  = 0;
            end else begin
                if (valvulas != prev) begin
                    if (prev != 4'd0) emitir(K_VALV, int'(prev), run);
                    prev = valvulas;
                    run  = (valvulas != 4'd0) ? 1 : 0;
                end else if (prev != 4'd0) begin
                    run++;
                end
                if (moneda_rechazo) emitir(K_RECH, 0, 0);
                if (saldo_insuf)    emitir(K_INSUF, 0, 0);
                if (vuelto_valido)  emitir(K_VUEL, int'(vuelto), int'(listo));
                else if (listo)     emitir(K_LISTO, 0, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic moneda(input int v);
        moneda_valida = 1'b1;
        moneda_valor  = 4'(v);
        tick();
        moneda_valida = 1'b0;
        moneda_valor  = 4'd0;
    endtask

    task automatic pedir(input logic [3:0] sel);
        cafe      = sel;
        confirmar = 1'b1;
        tick();
        confirmar = 1'b0;
    endtask

    task automatic esperar_libre(input string name);
        int n;
        n = 0;
        while (ocupado && n < 200) begin
            tick();
            n++;
        end
        chk(name, int'(ocupado), 0);
    endtask

    task automatic secuencia(input int tipo, input int cambio);
        esperar(K_VALV, 1, 8);
        esperar(K_VALV, 2, 8);
        if (tipo == 1) esperar(K_VALV, 4, 8);
        if (tipo == 2) esperar(K_VALV, 4, 16);
        if (tipo == 3) begin
            esperar(K_VALV, 4, 8);
            esperar(K_VALV, 8, 8);
        end
        esperar(K_VUEL, cambio, 1);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) tick();
        chk("rst_credito", int'(credito), 0);
        chk("rst_tipo", int'(tipoCafe), 0);
        chk("rst_valvulas", int'(valvulas), 0);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_vuelto", int'(vuelto), 0);
        chk("rst_pulsos", int'({vuelto_valido, moneda_rechazo, saldo_insuf, listo}), 0);
        rst_n = 1'b1;
        tick();

        // Expreso with change 1
        moneda(2);
        moneda(2);
        chk("t1_credito", int'(credito), 4);
        secuencia(0, 1);
        pedir(4'b0001);
        chk("t1_ocupado", int'(ocupado), 1);
        chk("t1_tipo", int'(tipoCafe), 0);
        esperar_libre("t1_fin");
        chk("t1_credito_fin", int'(credito), 0);

        // Insufficient mocaccino, then exact credit
        moneda(5);
        esperar(K_INSUF, 0, 0);
        pedir(4'b1000);
        chk("t2_no_prepara", int'(ocupado), 0);
        chk("t2_credito", int'(credito), 5);
        moneda(2);
        secuencia(3, 0);
        pedir(4'b1000);
        chk("t2_tipo", int'(tipoCafe), 3);
        esperar_libre("t2_fin");

        // Credit ceiling, zero coin, cancel refund, confirm in ESPERA
        moneda(8);
        moneda(7);
        esperar(K_RECH, 0, 0);
        moneda(1);
        chk("t3_credito15", int'(credito), 15);
        esperar(K_RECH, 0, 0);
        moneda(0);
        esperar(K_VUEL, 15, 0);
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        chk("t3_credito0", int'(credito), 0);
        esperar(K_INSUF, 0, 0);
        pedir(4'b0001);
        chk("t3_espera", int'(ocupado), 0);

        // Coin, cancel and selection change during PREPARA
        moneda(4);
        pedir(4'b0010);
        esperar(K_RECH, 0, 0);
        moneda(3);
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        cafe = 4'b0001;
        tick();
        chk("t4_credito", int'(credito), 4);
        chk("t4_ocupado", int'(ocupado), 1);
        secuencia(1, 0);
        esperar_libre("t4_fin");

        // Cancel wins over confirm
        moneda(6);
        esperar(K_VUEL, 6, 0);
        cafe = 4'b0001;
        confirmar = 1'b1;
        cancelar = 1'b1;
        tick();
        confirmar = 1'b0;
        cancelar = 1'b0;
        chk("t5_ocupado", int'(ocupado), 0);
        chk("t5_credito", int'(credito), 0);

        // Coin with successful confirm: pre-coin check, coin joins change
        moneda(3);
        secuencia(0, 2);
        moneda_valida = 1'b1;
        moneda_valor = 4'd2;
        pedir(4'b0001);
        moneda_valida = 1'b0;
        chk("t6_credito", int'(credito), 5);
        esperar_libre("t6_fin");

        // Coin with refused confirm: coin still accepted
        moneda(2);
        esperar(K_INSUF, 0, 0);
        moneda_valida = 1'b1;
        moneda_valor = 4'd2;
        pedir(4'b0010);
        moneda_valida = 1'b0;
        chk("t6b_credito", int'(credito), 4);
        esperar(K_VUEL, 4, 0);
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;

        // Asynchronous reset during the leche step
        moneda(4);
        esperar(K_VALV, 1, 8);
        esperar(K_VALV, 2, 8);
        pedir(4'b0010);
        repeat (18) tick();
        chk("t7_leche", int'(valvulas), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_valv_async", int'(valvulas), 0);
        chk("t7_ocupado", int'(ocupado), 0);
        chk("t7_credito", int'(credito), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t7_tipo", int'(tipoCafe), 0);
        chk("t7_credito_post", int'(credito), 0);
        moneda(3);
        secuencia(0, 0);
        pedir(4'b0001);
        esperar_libre("t7_fin");

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        repeat (5) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
